// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add / restoring).
// Ports: clk, rst (async, active-high), start, flush, op[2:0], a, b ->
//        busy, done (1-cycle pulse), result (registered, held).
// Option: define MULDIV_FASTPATH_EN to let divide-by-zero, signed overflow
//         and zero operands bypass the iterations (2-cycle latency).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic               fast_q, fast_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // operand conditioning for capture
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             dz_start, ovf_start;

    always_comb begin
        a_signed  = (op == 3'b001) || (op == 3'b010) ||
                    (op == 3'b100) || (op == 3'b110);
        b_signed  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg     = a_signed && a[WIDTH-1];
        b_neg     = b_signed && b[WIDTH-1];
        a_abs     = a_neg ? -a : a;
        b_abs     = b_neg ? -b : b;
        dz_start  = op[2] && (b == '0);
        ovf_start = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    end

    // one iteration of each datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                  (acc_q[0] ? {1'b0, opa_q} : '0);
        mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
        div_sh  = {rem_q, quo_q[WIDTH-1]};
        div_ge  = div_sh >= {1'b0, opb_q};
        // when div_ge the difference always fits in WIDTH bits
        rem_nxt = div_ge ? (div_sh[WIDTH-1:0] - opb_q) : div_sh[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], div_ge};
    end

    // sign fix and result selection after the last iteration
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, sel_res, fin_res;

    always_comb begin
        prod_fix = neg_q ? -mul_nxt : mul_nxt;
        quo_fix  = neg_q ? -quo_nxt : quo_nxt;
        rem_fix  = neg_q ? -rem_nxt : rem_nxt;
        sel_res  = '0;
        unique case (op_q)
            3'b000:                 sel_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: sel_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         sel_res = quo_fix;
            default:                sel_res = rem_fix;
        endcase
        if (dz_q) begin
            fin_res = op_q[1] ? a_raw_q : '1;
        end else if (ovf_q) begin
            fin_res = op_q[1] ? '0 : MIN_NEG;
        end else if (fast_q) begin
            // a bypassed zero operand always yields zero
            fin_res = '0;
        end else begin
            fin_res = sel_res;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        fast_d   = fast_q;
        a_raw_d  = a_raw_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    a_raw_d = a;
                    opa_d   = a_abs;
                    opb_d   = b_abs;
                    neg_d   = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
                    dz_d    = dz_start;
                    ovf_d   = ovf_start;
`ifdef MULDIV_FASTPATH_EN
                    fast_d  = (a == '0) || (b == '0) || ovf_start;
`else
                    fast_d  = 1'b0;
`endif
                    acc_d   = {{WIDTH{1'b0}}, b_abs};
                    quo_d   = a_abs;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        quo_d = quo_nxt;
                        rem_d = rem_nxt;
                    end else begin
                        acc_d = mul_nxt;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST || fast_q) begin
                        result_d = fin_res;
                        cnt_d    = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            fast_q   <= 1'b0;
            a_raw_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            fast_q   <= fast_d;
            a_raw_q  <= a_raw_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the single-cycle `alu`. It consumes the same operand pair (`a`, `b`) the ALU receives from the register-read stage. It also takes the instruction's funct3 as `op`. It returns a 32-bit result to the same writeback mux as the ALU result, and stalls the pipeline through `busy` while an operation is in flight.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `flush`  in  1  abort current operation (pipeline flush)
- `op`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  WIDTH  rs1 operand (dividend / multiplicand)
- `b`  in  WIDTH  rs2 operand (divisor / multiplier)
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse; `result` valid in the same cycle
- `result`  out  WIDTH  registered result; held until the next accepted `start`

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, `busy`=0, `done`=0, `result`=0, iteration counter 0.
- IDLE with `start`=1: register `op`, `a` and `b`. Take the absolute values of signed operands:
  - `a` is signed for MULH, MULHSU, DIV and REM.
  - `b` is signed for MULH, DIV and REM.
- Record the result sign:
  - Multiply: XOR of the operand signs.
  - DIV: XOR of the operand signs.
  - REM: sign of the dividend.
- Then go to CALC with counter=0.
- CALC multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC divide: restoring division, one quotient bit per cycle, with a WIDTH+1 partial remainder.
- After iteration WIDTH-1, apply the sign fix (two's complement of the 2·WIDTH product, quotient or remainder as required). Load `result` and go to DONE.
- Result selection:
  - MUL: low half of the product.
  - MULH, MULHSU, MULHU: high half of the product.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- Divide by zero follows the RISC-V rules, with no trap:
  - DIV and DIVU: quotient = all ones.
  - REM and REMU: remainder = dividend `a`.
- Signed overflow (DIV/REM with `a`=0x80000000, `b`=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- `start` while `busy`=1 is ignored; the captured operands are never overwritten mid-operation.
- `flush`=1 in CALC or DONE forces IDLE at the next edge:
  - No `done` pulse is produced for the aborted operation.
  - `result` keeps its previous value.
- `flush` and `start` both high in IDLE: `flush` wins, no capture.
- Asynchronous `rst` mid-operation returns every output to its reset value immediately.

## Timing
- Start accepted at edge E0, so `busy`=1 after E0.
- Iterations occur at edges E1..E32, and `result` is loaded at E32.
- `done`=1 between E32 and E33. `busy` falls after E33.
- Full latency: start to done = 33 cycles. Issue-to-issue = 34 cycles.
- `result` changes only at the edge entering DONE; it is stable at all other times.

## Configuration
- `MULDIV_FASTPATH_EN` defined: divide-by-zero, signed overflow, and any operation with `a`=0 or `b`=0 skip CALC. The final value is loaded at E0+1 and `done` is high in the following cycle (latency 2 instead of 33).
- Undefined: every operation takes the full 33-cycle path; special cases produce the same values via the iterative datapath plus final override.

## Test plan
- MUL 7 × 6 -> `done` 33 cycles after start (without macro), `result`=42, `busy` high for the whole interval.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV −7 / 2 -> 0xFFFFFFFD (−3); REM −7 / 2 -> 0xFFFFFFFF (−1); DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 5. DIV 0x80000000 / −1 -> 0x80000000, REM -> 0. Latency is 2 with `MULDIV_FASTPATH_EN` and 33 without.
- Second `start` with new operands at cycle 10 of a MUL -> ignored, first result unchanged. `flush` at cycle 15 -> IDLE next cycle, no `done`, `result` keeps its prior value.
- Assert `rst` mid-CALC -> `busy`, `done`, `result` = 0 without waiting for a clock edge. A following MUL 3 × 3 -> 9.
